mem_arbiter: RTL and testbench

//  Shares the single byte-wide RAM port between the IF stage (instruction fetch) and the MEM stage
//  (loads/stores leaving the EX->MEM pipeline register). Serialises each access into byte beats.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one RAM port between instruction fetch (IF) and load/store (MEM).
// MEM has fixed priority; each access is split into byte beats and reassembled little-endian.
//
// state | meaning
// IDLE  | no access in flight; requests sampled here (MEM before IF)
// READ  | issuing read addresses, capturing ram_din one cycle behind
// WRITE | issuing one store byte per cycle
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [1:0]            mem_width,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic                  stall_req_if,
    output logic                  stall_req_mem
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    state_t                state;
    owner_t                owner;
    logic [2:0]            cnt;
    logic [2:0]            len;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           wdata;
    logic [31:0]           rbuf;

    logic [31:0]           buf_next;
    logic [31:0]           word_out;
    logic [1:0]            cap_idx;
    logic                  addr_active;

    // ram_din carries the byte addressed in the previous beat
    assign cap_idx = cnt[1:0] - 2'd1;

    always_comb begin
        buf_next = rbuf;
        buf_next[{cap_idx, 3'b000} +: 8] = ram_din;
        case (len)
            3'd1:    word_out = {24'h0, buf_next[7:0]};
            3'd2:    word_out = {16'h0, buf_next[15:0]};
            default: word_out = buf_next;
        endcase
    end

    assign addr_active = ((state == READ) && (cnt < len)) || (state == WRITE);
    assign ram_a    = addr_active ? base + ADDR_WIDTH'(cnt) : '0;
    assign ram_dout = (state == WRITE) ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;
    assign ram_wr   = (state == WRITE) && rdy_in;

    assign stall_req_if  = if_req & ~if_done;
    assign stall_req_mem = mem_req & ~mem_done;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            cnt       <= 3'd0;
            len       <= 3'd0;
            base      <= '0;
            wdata     <= 32'h0;
            rbuf      <= 32'h0;
            if_done   <= 1'b0;
            if_data   <= 32'h0;
            mem_done  <= 1'b0;
            mem_rdata <= 32'h0;
        end else if (rdy_in) begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (mem_req) begin
                        owner <= OWN_MEM;
                        base  <= mem_addr;
                        wdata <= mem_wdata;
                        case (mem_width)
                            2'b00:   len <= 3'd1;
                            2'b01:   len <= 3'd2;
                            default: len <= 3'd4;
                        endcase
                        state <= mem_we ? WRITE : READ;
                    end else if (if_req && !flush) begin
                        owner <= OWN_IF;
                        base  <= if_addr;
                        len   <= 3'd4;
                        state <= READ;
                    end
                end
                READ: begin
                    if (owner == OWN_IF && flush) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        if (cnt != 3'd0)
                            rbuf <= buf_next;
                        if (cnt == len) begin
                            state <= IDLE;
                            cnt   <= 3'd0;
                            if (owner == OWN_IF) begin
                                if_done <= 1'b1;
                                if_data <= word_out;
                            end else begin
                                mem_done  <= 1'b1;
                                mem_rdata <= word_out;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    if (cnt == len - 3'd1) begin
                        state    <= IDLE;
                        cnt      <= 3'd0;
                        mem_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-content RAM model, write log, hand-computed expectations.
module tb_mem_arbiter;

    localparam int AW = 32;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          rdy_in = 1'b1;
    logic          flush = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [1:0]    mem_width = 2'b00;
    logic [AW-1:0] mem_addr = '0;
    logic [31:0]   mem_wdata = 32'h0;
    logic [7:0]    ram_din = 8'h00;
    logic [7:0]    ram_dout;
    logic [AW-1:0] ram_a;
    logic          ram_wr;
    logic          if_done;
    logic [31:0]   if_data;
    logic          mem_done;
    logic [31:0]   mem_rdata;
    logic          stall_req_if;
    logic          stall_req_mem;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    logic [7:0] wr_mem [logic [31:0]];

    mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .if_req(if_req), .if_addr(if_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .if_done(if_done), .if_data(if_data), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100: rom = 8'h13;
            32'h101: rom = 8'h00;
            32'h102: rom = 8'h00;
            32'h103: rom = 8'h93;
            32'h200: rom = 8'h01;
            32'h201: rom = 8'h02;
            32'h202: rom = 8'h03;
            32'h203: rom = 8'h04;
            32'h020: rom = 8'h80;
            32'h021: rom = 8'hFF;
            32'h022: rom = 8'h55;
            default: rom = 8'h00;
        endcase
    endfunction

    always @(posedge clk_in) begin
        ram_din <= rom(ram_a);
        if (ram_wr) begin
            wr_mem[ram_a] = ram_dout;
            wr_count = wr_count + 1;
        end
    end

    function automatic logic [7:0] wbyte(input logic [31:0] a);
        wbyte = wr_mem.exists(a) ? wr_mem[a] : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    initial begin
        int          wr0;
        logic [31:0] wd;

        step();
        chk("rst_if_done", {31'h0, if_done}, 32'h0);
        chk("rst_mem_done", {31'h0, mem_done}, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
        rst_in = 1'b0;
        step();

        // word fetch
        if_req = 1'b1; if_addr = 32'h100;
        #1 chk("f_stall_pre", {31'h0, stall_req_if}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("f_ram_a", ram_a, 32'h100 + k);
            chk("f_ram_wr", {31'h0, ram_wr}, 32'h0);
        end
        step();
        chk("f_done_early", {31'h0, if_done}, 32'h0);
        chk("f_ram_a_idle", ram_a, 32'h0);
        step();
        chk("f_done", {31'h0, if_done}, 32'h1);
        chk("f_data", if_data, 32'h93000013);
        chk("f_stall_done", {31'h0, stall_req_if}, 32'h0);
        if_req = 1'b0;
        step();
        chk("f_done_pulse", {31'h0, if_done}, 32'h0);
        chk("f_data_hold", if_data, 32'h93000013);

        // store byte
        wr0 = wr_count;
        mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b00;
        mem_addr = 32'h30004; mem_wdata = 32'hDEADBEEF;
        step();
        chk("sb_wr", {31'h0, ram_wr}, 32'h1);
        chk("sb_a", ram_a, 32'h30004);
        chk("sb_dout", {24'h0, ram_dout}, 32'hEF);
        chk("sb_done_early", {31'h0, mem_done}, 32'h0);
        step();
        chk("sb_done", {31'h0, mem_done}, 32'h1);
        chk("sb_stall", {31'h0, stall_req_mem}, 32'h0);
        chk("sb_wr_after", {31'h0, ram_wr}, 32'h0);
        mem_req = 1'b0;
        step();
        chk("sb_count", wr_count - wr0, 32'd1);
        chk("sb_byte", {24'h0, wbyte(32'h30004)}, 32'hEF);

        // half load, upper bytes zero despite stale buffer contents
        mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'b01; mem_addr = 32'h20;
        for (int k = 0; k < 3; k++) step();
        chk("hl_done_early", {31'h0, mem_done}, 32'h0);
        step();
        chk("hl_done", {31'h0, mem_done}, 32'h1);
        chk("hl_rdata", mem_rdata, 32'h0000FF80);
        mem_req = 1'b0;
        step();

        // contention: word store wins, then IF fetch
        wr0 = wr_count;
        wd = 32'h11223344;
        if_req = 1'b1; if_addr = 32'h200;
        mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b10; mem_addr = 32'h40; mem_wdata = wd;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("c_wr", {31'h0, ram_wr}, 32'h1);
            chk("c_a", ram_a, 32'h40 + k);
            chk("c_dout", {24'h0, ram_dout}, {24'h0, wd[8*k +: 8]});
            chk("c_if_stall", {31'h0, stall_req_if}, 32'h1);
        end
        step();
        chk("c_mem_done", {31'h0, mem_done}, 32'h1);
        chk("c_idle_wr", {31'h0, ram_wr}, 32'h0);
        chk("c_idle_a", ram_a, 32'h0);
        chk("c_wr_count", wr_count - wr0, 32'd4);
        mem_req = 1'b0;
        step();
        chk("c_if_start", ram_a, 32'h200);
        for (int k = 0; k < 4; k++) step();
        chk("c_if_early", {31'h0, if_done}, 32'h0);
        step();
        chk("c_if_done", {31'h0, if_done}, 32'h1);
        chk("c_if_data", if_data, 32'h04030201);
        if_req = 1'b0;
        step();

        // flush in the middle of an IF read
        if_req = 1'b1; if_addr = 32'h100;
        step(); step(); step();
        chk("fl_cnt2_a", ram_a, 32'h102);
        flush = 1'b1;
        step();
        chk("fl_no_done", {31'h0, if_done}, 32'h0);
        chk("fl_idle_a", ram_a, 32'h0);
        chk("fl_data_kept", if_data, 32'h04030201);
        flush = 1'b0; if_addr = 32'h200;
        step();
        chk("fl_restart", ram_a, 32'h200);
        for (int k = 0; k < 5; k++) step();
        chk("fl_re_done", {31'h0, if_done}, 32'h1);
        chk("fl_re_data", if_data, 32'h04030201);
        if_req = 1'b0;
        step();

        // flush does not affect a MEM word load
        mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'b10; mem_addr = 32'h100; flush = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("fm_done", {31'h0, mem_done}, 32'h1);
        chk("fm_rdata", mem_rdata, 32'h93000013);
        mem_req = 1'b0; flush = 1'b0;
        step();

        // rdy_in low for three cycles in the middle of a word store
        wr0 = wr_count;
        mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b11; mem_addr = 32'h50; mem_wdata = 32'hA1B2C3D4;
        step(); step();
        chk("rd_a1", ram_a, 32'h51);
        rdy_in = 1'b0;
        #1 chk("rd_wr_off", {31'h0, ram_wr}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rd_hold_wr", {31'h0, ram_wr}, 32'h0);
            chk("rd_hold_a", ram_a, 32'h51);
        end
        rdy_in = 1'b1;
        #1 chk("rd_resume_dout", {24'h0, ram_dout}, 32'hC3);
        step();
        chk("rd_a2", ram_a, 32'h52);
        step();
        chk("rd_a3", ram_a, 32'h53);
        step();
        chk("rd_done", {31'h0, mem_done}, 32'h1);
        chk("rd_count", wr_count - wr0, 32'd4);
        chk("rd_mem", {wbyte(32'h53), wbyte(32'h52), wbyte(32'h51), wbyte(32'h50)}, 32'hA1B2C3D4);
        mem_req = 1'b0; rdy_in = 1'b0;
        step();
        chk("rd_done_stretch", {31'h0, mem_done}, 32'h1);
        rdy_in = 1'b1;
        step();
        chk("rd_done_clear", {31'h0, mem_done}, 32'h0);

        // asynchronous reset during an IF read
        if_req = 1'b1; if_addr = 32'h100;
        step(); step();
        chk("ar_busy_a", ram_a, 32'h101);
        #2 rst_in = 1'b1;
        #1;
        chk("ar_ram_a", ram_a, 32'h0);
        chk("ar_if_data", if_data, 32'h0);
        chk("ar_mem_rdata", mem_rdata, 32'h0);
        chk("ar_mem_done", {31'h0, mem_done}, 32'h0);
        step();
        rst_in = 1'b0; if_addr = 32'h200;
        step();
        chk("ar_restart", ram_a, 32'h200);
        for (int k = 0; k < 5; k++) step();
        chk("ar_done", {31'h0, if_done}, 32'h1);
        chk("ar_data", if_data, 32'h04030201);
        if_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
